// File: rtl/gamepad_responder.sv
`default_nettype none
// ============================================================================
// Module      : gamepad_responder
// Description : Serial-side emulator of a 4021-based NES-style gamepad.
//               A host supplies an 8-bit button word (1 = pressed) through a
//               strobed staging register. The pad controller's asynchronous
//               latch and pulse lines are synchronised and edge-detected. The
//               button word is then parallel-loaded and shifted out active-low
//               on GamePadData, exactly as a physical pad would present it.
//
// Parameters  : SYNC_STAGES    - synchroniser depth on GLatch/GPulse (>= 2)
//               TIMEOUT_CYCLES - idle cycles tolerated in SHIFT (1..65535)
//               FILTER_CYCLES  - stable cycles needed by the glitch filter
//
// Ports       : Clock        in   system clock, rising edge
//               Reset        in   synchronous, active-low reset
//               Buttons      in   [0]=A [1]=B [2]=Select [3]=Start
//                                 [4]=Up [5]=Down [6]=Left [7]=Right
//               ButtonsValid in   strobe, captures Buttons into staging
//               GLatch       in   asynchronous latch line from controller
//               GPulse       in   asynchronous clock line from controller
//               GamePadData  out  serial data, active-low, registered
//               Busy         out  high whenever the FSM is not IDLE
//               FrameDone    out  one-cycle pulse when the 8th bit is taken
//               FrameAbort   out  one-cycle pulse on restart or timeout
//               BitCount     out  pulses consumed in the current frame
//
// Config      : GAMEPAD_RESPONDER_FILTER_EN - when defined, a glitch filter
//               sits after the synchronisers. Each line changes its internal
//               level only after FILTER_CYCLES consecutive cycles at the new
//               level. When undefined, any synchronised change is an edge.
//
// Revision    : 1.0 - initial release
// ============================================================================
module gamepad_responder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF,
    parameter int unsigned FILTER_CYCLES  = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Buttons,
    input  logic       ButtonsValid,
    input  logic       GLatch,
    input  logic       GPulse,
    output logic       GamePadData,
    output logic       Busy,
    output logic       FrameDone,
    output logic       FrameAbort,
    output logic [3:0] BitCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] TMO_MAX   = 16'hFFFF;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic [SYNC_STAGES-1:0] pulse_sync_q, pulse_sync_d;

    // Internal line levels after optional filtering
    logic latch_lvl_in;
    logic pulse_lvl_in;

    // Edge detection: previous level plus registered edge strobes. The
    // strobes are registered so the FSM sees a clean single-cycle event
    // one edge after the level flop updates.
    logic latch_lvl_q,  latch_lvl_d;
    logic pulse_lvl_q,  pulse_lvl_d;
    logic latch_rise_q, latch_rise_d;
    logic latch_fall_q, latch_fall_d;
    logic pulse_rise_q, pulse_rise_d;

    // ------------------------------------------------------------------
    // Datapath / FSM state
    // ------------------------------------------------------------------
    state_t      state_q,   state_d;
    logic [7:0]  staged_q,  staged_d;
    logic [7:0]  sr_q,      sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] tmo_q,     tmo_d;
    logic        data_q,    data_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        abort_q,   abort_d;

    // Value presented to the shift register on any parallel load. A
    // strobe in the same cycle as the load takes precedence over the
    // staged copy so the host never loses a freshly written word.
    logic [7:0]  load_val;

    always_comb begin
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], GLatch};
        pulse_sync_d = {pulse_sync_q[SYNC_STAGES-2:0], GPulse};
    end

`ifdef GAMEPAD_RESPONDER_FILTER_EN
    // ------------------------------------------------------------------
    // Glitch filter. The counter tracks how many consecutive cycles the
    // synchronised line has disagreed with the filtered level. The level
    // flips on the FILTER_CYCLES-th disagreeing cycle. Any agreeing cycle
    // restarts the count, so shorter glitches are discarded.
    // ------------------------------------------------------------------
    localparam logic [15:0] FILT_LAST = 16'(FILTER_CYCLES - 1);

    logic        latch_filt_q, latch_filt_d;
    logic        pulse_filt_q, pulse_filt_d;
    logic [15:0] latch_fcnt_q, latch_fcnt_d;
    logic [15:0] pulse_fcnt_q, pulse_fcnt_d;

    always_comb begin
        latch_filt_d = latch_filt_q;
        latch_fcnt_d = '0;
        if (latch_sync_q[SYNC_STAGES-1] != latch_filt_q) begin
            if (latch_fcnt_q == FILT_LAST) begin
                latch_filt_d = latch_sync_q[SYNC_STAGES-1];
            end else begin
                latch_fcnt_d = latch_fcnt_q + 16'd1;
            end
        end

        pulse_filt_d = pulse_filt_q;
        pulse_fcnt_d = '0;
        if (pulse_sync_q[SYNC_STAGES-1] != pulse_filt_q) begin
            if (pulse_fcnt_q == FILT_LAST) begin
                pulse_filt_d = pulse_sync_q[SYNC_STAGES-1];
            end else begin
                pulse_fcnt_d = pulse_fcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            latch_filt_q <= 1'b0;
            pulse_filt_q <= 1'b0;
            latch_fcnt_q <= '0;
            pulse_fcnt_q <= '0;
        end else begin
            latch_filt_q <= latch_filt_d;
            pulse_filt_q <= pulse_filt_d;
            latch_fcnt_q <= latch_fcnt_d;
            pulse_fcnt_q <= pulse_fcnt_d;
        end
    end

    assign latch_lvl_in = latch_filt_q;
    assign pulse_lvl_in = pulse_filt_q;
`else
    // Without the filter the synchronised levels feed edge detection
    // directly. The filter depth has no effect in this build.
    logic unused_filter_cfg;
    assign unused_filter_cfg = (FILTER_CYCLES != 0);

    assign latch_lvl_in = latch_sync_q[SYNC_STAGES-1];
    assign pulse_lvl_in = pulse_sync_q[SYNC_STAGES-1];
`endif

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    always_comb begin
        latch_lvl_d  = latch_lvl_in;
        pulse_lvl_d  = pulse_lvl_in;
        latch_rise_d = latch_lvl_in & ~latch_lvl_q;
        latch_fall_d = ~latch_lvl_in & latch_lvl_q;
        pulse_rise_d = pulse_lvl_in & ~pulse_lvl_q;
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        load_val  = ButtonsValid ? Buttons : staged_q;
        staged_d  = load_val;

        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = '0;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        case (state_q)
            // DONE lasts one cycle and otherwise behaves like IDLE, so a
            // latch arriving right after a frame is not lost.
            ST_IDLE, ST_DONE: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                if (latch_rise_q) begin
                    state_d = ST_LATCH;
                    sr_d    = load_val;
                end
            end

            // Parallel mode: the register tracks the button word for as
            // long as the latch stays high. Pulse edges have no effect.
            ST_LATCH: begin
                if (latch_fall_q) begin
                    state_d = ST_SHIFT;
                end else begin
                    sr_d = load_val;
                end
            end

            ST_SHIFT: begin
                if (latch_rise_q) begin
                    // Controller restarted mid-frame
                    state_d   = ST_LATCH;
                    sr_d      = load_val;
                    bit_cnt_d = '0;
                    abort_d   = 1'b1;
                end else if (pulse_rise_q) begin
                    sr_d      = {1'b0, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    // Saturating idle counter; never wraps back to zero
                    tmo_d = (tmo_q == TMO_MAX) ? tmo_q : (tmo_q + 16'd1);
                    if (tmo_d >= TMO_LIMIT) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        abort_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Outputs are computed from the next state so that the data bit
        // captured on entry to LATCH is presented on that same edge.
        data_d = ((state_d == ST_LATCH) || (state_d == ST_SHIFT)) ? ~sr_d[0] : 1'b1;
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            latch_lvl_q  <= 1'b0;
            pulse_lvl_q  <= 1'b0;
            latch_rise_q <= 1'b0;
            latch_fall_q <= 1'b0;
            pulse_rise_q <= 1'b0;
            state_q      <= ST_IDLE;
            staged_q     <= '0;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            data_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            latch_sync_q <= latch_sync_d;
            pulse_sync_q <= pulse_sync_d;
            latch_lvl_q  <= latch_lvl_d;
            pulse_lvl_q  <= pulse_lvl_d;
            latch_rise_q <= latch_rise_d;
            latch_fall_q <= latch_fall_d;
            pulse_rise_q <= pulse_rise_d;
            state_q      <= state_d;
            staged_q     <= staged_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    assign GamePadData = data_q;
    assign Busy        = busy_q;
    assign FrameDone   = done_q;
    assign FrameAbort  = abort_q;
    assign BitCount    = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gamepad_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gamepad_responder
// Description : Self-checking bench for gamepad_responder. Expected serial
//               bits are queued when a frame is set up and compared as each
//               bit is read back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gamepad_responder;

    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int TMO  = 100;
`ifdef GAMEPAD_RESPONDER_FILTER_EN
    localparam int FLAT    = FILT;
    localparam bit FILT_ON = 1'b1;
`else
    localparam int FLAT    = 0;
    localparam bit FILT_ON = 1'b0;
`endif
    // Posedges from a pin change (driven at a negedge) to the edge it acts on
    localparam int ACT  = SYNC + 2 + FLAT;
    localparam int HOLD = ACT + 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Buttons = 8'h00;
    logic       ButtonsValid = 1'b0;
    logic       GLatch = 1'b0;
    logic       GPulse = 1'b0;
    logic       GamePadData;
    logic       Busy;
    logic       FrameDone;
    logic       FrameAbort;
    logic [3:0] BitCount;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    logic sb[$];

    gamepad_responder #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_CYCLES (FILT)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Buttons     (Buttons),
        .ButtonsValid(ButtonsValid),
        .GLatch      (GLatch),
        .GPulse      (GPulse),
        .GamePadData (GamePadData),
        .Busy        (Busy),
        .FrameDone   (FrameDone),
        .FrameAbort  (FrameAbort),
        .BitCount    (BitCount)
    );

    always #20 Clock = ~Clock;

    always @(negedge Clock) begin
        if (FrameDone === 1'b1)  done_cnt  = done_cnt + 1;
        if (FrameAbort === 1'b1) abort_cnt = abort_cnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic load_buttons(input logic [7:0] b);
        Buttons = b; ButtonsValid = 1'b1;
        wait_cyc(1);
        ButtonsValid = 1'b0;
    endtask

    // Pad model: bit i of the word appears inverted as the i-th serial bit
    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sb.push_back(~b[i]);
    endtask

    task automatic latch_frame();
        GLatch = 1'b1; wait_cyc(HOLD);
        GLatch = 1'b0; wait_cyc(HOLD);
    endtask

    task automatic pulse();
        GPulse = 1'b1; wait_cyc(HOLD);
        GPulse = 1'b0; wait_cyc(HOLD);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b0; wait_cyc(3);
        n_checks++; if (GamePadData !== 1'b1) begin n_fail++; $display("FAIL reset_data: got %b want 1", GamePadData); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_checks++; if (FrameDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", FrameDone); end
        n_checks++; if (FrameAbort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", FrameAbort); end
        n_checks++; if (BitCount !== 4'd0) begin n_fail++; $display("FAIL reset_bitcount: got %0d want 0", BitCount); end
        Reset = 1'b1; wait_cyc(2);
    endtask

    task automatic test_frame();
        logic e;
        int d0;
        load_buttons(8'h09);
        push_frame(8'h09);
        latch_frame();
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy: got %b want 1", Busy); end
        n_checks++; if (BitCount !== 4'd0) begin n_fail++; $display("FAIL frame_bc0: got %0d want 0", BitCount); end
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            e = sb.pop_front();
            n_checks++; if (GamePadData !== e) begin n_fail++; $display("FAIL frame_bit%0d: got %b want %b", i, GamePadData, e); end
            GPulse = 1'b1;
            wait_cyc(ACT - 1);
            n_checks++; if (BitCount !== 4'(i)) begin n_fail++; $display("FAIL frame_early%0d: got %0d want %0d", i, BitCount, i); end
            wait_cyc(1);
            if (i == 7) begin
                n_checks++; if (BitCount !== 4'd8) begin n_fail++; $display("FAIL frame_bc8: got %0d want 8", BitCount); end
                n_checks++; if (FrameDone !== 1'b1) begin n_fail++; $display("FAIL frame_done: got %b want 1", FrameDone); end
                n_checks++; if (GamePadData !== 1'b1) begin n_fail++; $display("FAIL frame_done_data: got %b want 1", GamePadData); end
                wait_cyc(1);
                n_checks++; if (BitCount !== 4'd0) begin n_fail++; $display("FAIL frame_idle_bc: got %0d want 0", BitCount); end
                n_checks++; if (FrameDone !== 1'b0) begin n_fail++; $display("FAIL frame_done_len: got %b want 0", FrameDone); end
                n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL frame_idle_busy: got %b want 0", Busy); end
                wait_cyc(HOLD - ACT - 1);
            end else begin
                n_checks++; if (BitCount !== 4'(i + 1)) begin n_fail++; $display("FAIL frame_bc%0d: got %0d want %0d", i + 1, BitCount, i + 1); end
                wait_cyc(HOLD - ACT);
            end
            GPulse = 1'b0;
            wait_cyc(HOLD);
        end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", done_cnt - d0); end
        // Extra pulse while idle must be ignored
        pulse();
        n_checks++; if (GamePadData !== 1'b1) begin n_fail++; $display("FAIL idle_pulse_data: got %b want 1", GamePadData); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL idle_pulse_busy: got %b want 0", Busy); end
    endtask

    task automatic test_parallel();
        logic e;
        load_buttons(8'h00);
        GLatch = 1'b1; wait_cyc(HOLD);
        n_checks++; if (GamePadData !== 1'b1) begin n_fail++; $display("FAIL par_released: got %b want 1", GamePadData); end
        load_buttons(8'hFF);
        wait_cyc(1);
        n_checks++; if (GamePadData !== 1'b0) begin n_fail++; $display("FAIL par_pressed: got %b want 0", GamePadData); end
        GLatch = 1'b0; wait_cyc(HOLD);
        push_frame(8'hFF);
        for (int i = 0; i < 8; i++) begin
            e = sb.pop_front();
            n_checks++; if (GamePadData !== e) begin n_fail++; $display("FAIL par_bit%0d: got %b want %b", i, GamePadData, e); end
            pulse();
        end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL par_end_busy: got %b want 0", Busy); end
    endtask

    task automatic test_restart();
        logic e;
        int a0, d0;
        load_buttons(8'hA5);
        push_frame(8'hA5);
        latch_frame();
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            n_checks++; if (GamePadData !== e) begin n_fail++; $display("FAIL rst_pre_bit%0d: got %b want %b", i, GamePadData, e); end
            pulse();
        end
        n_checks++; if (BitCount !== 4'd3) begin n_fail++; $display("FAIL rst_bc3: got %0d want 3", BitCount); end
        sb.delete();
        push_frame(8'hA5);
        a0 = abort_cnt; d0 = done_cnt;
        GLatch = 1'b1; wait_cyc(ACT);
        n_checks++; if (FrameAbort !== 1'b1) begin n_fail++; $display("FAIL rst_abort: got %b want 1", FrameAbort); end
        n_checks++; if (BitCount !== 4'd0) begin n_fail++; $display("FAIL rst_bc0: got %0d want 0", BitCount); end
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", Busy); end
        wait_cyc(1);
        n_checks++; if (FrameAbort !== 1'b0) begin n_fail++; $display("FAIL rst_abort_len: got %b want 0", FrameAbort); end
        wait_cyc(HOLD - ACT - 1);
        GLatch = 1'b0; wait_cyc(HOLD);
        for (int i = 0; i < 8; i++) begin
            e = sb.pop_front();
            n_checks++; if (GamePadData !== e) begin n_fail++; $display("FAIL rst_bit%0d: got %b want %b", i, GamePadData, e); end
            pulse();
        end
        n_checks++; if (abort_cnt - a0 !== 1) begin n_fail++; $display("FAIL rst_abort_count: got %0d want 1", abort_cnt - a0); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rst_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_timeout();
        int a0;
        load_buttons(8'h81);
        latch_frame();
        pulse();
        a0 = abort_cnt;
        GPulse = 1'b1; wait_cyc(ACT);
        n_checks++; if (BitCount !== 4'd2) begin n_fail++; $display("FAIL tmo_bc2: got %0d want 2", BitCount); end
        wait_cyc(HOLD - ACT);
        GPulse = 1'b0;
        wait_cyc(TMO - 1 - (HOLD - ACT));
        n_checks++; if (FrameAbort !== 1'b0) begin n_fail++; $display("FAIL tmo_early_abort: got %b want 0", FrameAbort); end
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early_busy: got %b want 1", Busy); end
        wait_cyc(1);
        n_checks++; if (FrameAbort !== 1'b1) begin n_fail++; $display("FAIL tmo_abort: got %b want 1", FrameAbort); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b want 0", Busy); end
        n_checks++; if (GamePadData !== 1'b1) begin n_fail++; $display("FAIL tmo_data: got %b want 1", GamePadData); end
        n_checks++; if (BitCount !== 4'd0) begin n_fail++; $display("FAIL tmo_bc: got %0d want 0", BitCount); end
        wait_cyc(1);
        n_checks++; if (abort_cnt - a0 !== 1) begin n_fail++; $display("FAIL tmo_abort_count: got %0d want 1", abort_cnt - a0); end
    endtask

    task automatic test_reset_mid();
        logic e;
        load_buttons(8'h3C);
        latch_frame();
        pulse();
        pulse();
        Reset = 1'b0; wait_cyc(1);
        Reset = 1'b1;
        n_checks++; if (GamePadData !== 1'b1) begin n_fail++; $display("FAIL rmid_data: got %b want 1", GamePadData); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", Busy); end
        n_checks++; if (BitCount !== 4'd0) begin n_fail++; $display("FAIL rmid_bc: got %0d want 0", BitCount); end
        n_checks++; if (FrameDone !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", FrameDone); end
        n_checks++; if (FrameAbort !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got %b want 0", FrameAbort); end
        wait_cyc(2);
        // Staging register was cleared: first bit reads released
        latch_frame();
        n_checks++; if (GamePadData !== 1'b1) begin n_fail++; $display("FAIL rmid_staged_clr: got %b want 1", GamePadData); end
        for (int i = 0; i < 8; i++) pulse();
        load_buttons(8'h3C);
        push_frame(8'h3C);
        latch_frame();
        for (int i = 0; i < 8; i++) begin
            e = sb.pop_front();
            n_checks++; if (GamePadData !== e) begin n_fail++; $display("FAIL rmid_bit%0d: got %b want %b", i, GamePadData, e); end
            pulse();
        end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rmid_end_busy: got %b want 0", Busy); end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        logic [3:0] exp_bc;
        b = 8'h02;
        load_buttons(b);
        latch_frame();
        GPulse = 1'b1; wait_cyc(2);
        GPulse = 1'b0; wait_cyc(HOLD);
        exp_bc = FILT_ON ? 4'd0 : 4'd1;
        n_checks++; if (BitCount !== exp_bc) begin n_fail++; $display("FAIL glitch_bc: got %0d want %0d", BitCount, exp_bc); end
        GPulse = 1'b1; wait_cyc(5);
        GPulse = 1'b0; wait_cyc(HOLD);
        exp_bc = exp_bc + 4'd1;
        n_checks++; if (BitCount !== exp_bc) begin n_fail++; $display("FAIL glitch_long_bc: got %0d want %0d", BitCount, exp_bc); end
        n_checks++; if (GamePadData !== ~b[exp_bc]) begin n_fail++; $display("FAIL glitch_data: got %b want %b", GamePadData, ~b[exp_bc]); end
        wait_cyc(TMO + 10);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL glitch_end_busy: got %b want 0", Busy); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_parallel();
        test_restart();
        test_timeout();
        test_reset_mid();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not complete within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/gamepad_responder.md
# gamepad_responder

Serial-side emulator of the NES-style gamepad that the gamepad controller polls. It samples the controller's latch and pulse lines, parallel-loads an 8-bit button word supplied by a host, and shifts it out active-low on the data line exactly as a 4021-based pad does. It is used for hardware loopback and bench stimulus of the gamepad input path without a physical pad, and runs on the 25 MHz CPU clock domain.

## Interface

Parameters:
- SYNC_STAGES, 2, synchronizer depth on GLatch/GPulse (min 2)
- TIMEOUT_CYCLES, 16'hFFFF, idle cycles allowed in SHIFT before abort (1..65535)
- FILTER_CYCLES, 3, stable-level cycles required by glitch filter (only with macro)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- Buttons  in  8  button word, 1 = pressed; [0]=A,[1]=B,[2]=Select,[3]=Start,[4]=Up,[5]=Down,[6]=Left,[7]=Right
- ButtonsValid  in  1  strobe; captures Buttons into staging register
- GLatch  in  1  asynchronous latch line from pad controller
- GPulse  in  1  asynchronous clock line from pad controller
- GamePadData  out  1  serial data, active-low (0 = pressed), registered
- Busy  out  1  high when state != IDLE
- FrameDone  out  1  one-cycle pulse on 8th pulse edge
- FrameAbort  out  1  one-cycle pulse on restart-mid-frame or timeout
- BitCount  out  4  pulses consumed in current frame (0..8)

## Operation

- Staging: ButtonsValid=1 loads Buttons into `staged` at the clock edge. Same-cycle load and latch capture: new Buttons value wins.
- GLatch/GPulse pass through SYNC_STAGES flops; one further flop gives rise/fall edges.
- Shift register `sr[7:0]`; GamePadData = ~sr[0] in LATCH/SHIFT, 1 in IDLE/DONE.
- States:
  - IDLE: latch rise -> LATCH, sr <= staged, BitCount <= 0.
  - LATCH: sr reloads from staged every cycle while latch high (parallel mode); pulse edges ignored; latch fall -> SHIFT.
  - SHIFT: pulse rise -> sr <= {1'b0, sr[7:1]}, BitCount+1, timeout counter cleared. When BitCount becomes 8 -> DONE, FrameDone=1. Latch rise -> LATCH with reload, BitCount<=0, FrameAbort=1. Timeout counter reaching TIMEOUT_CYCLES -> IDLE, FrameAbort=1.
  - DONE: one cycle, -> IDLE; latch rise in DONE treated as in IDLE.
- Pulse falls ignored everywhere; extra pulses in IDLE ignored (data stays 1).
- Timeout counter: 16-bit, counts only in SHIFT, saturates, no wrap.
- Reset (Reset=0 at an edge, any state): state IDLE, sr=0, staged=0, sync/edge flops=0, counter=0, GamePadData=1, Busy=0, FrameDone=0, FrameAbort=0, BitCount=0. Takes effect on that edge regardless of activity.

## Timing

- Pin change first sampled on edge k; internal edge acts and GamePadData/BitCount update on edge k+SYNC_STAGES+1 (plus FILTER_CYCLES with macro).
- GamePadData after latch capture valid at same edge LATCH is entered.
- FrameDone/FrameAbort high exactly one cycle, coincident with the state change.
- Inputs must hold each level ≥ SYNC_STAGES+1 cycles (≥ FILTER_CYCLES+SYNC_STAGES+1 with macro); NES timing at 25 MHz gives ≥150 cycles.

## Configuration

- GAMEPAD_RESPONDER_FILTER_EN defined: after synchronizers, each of latch/pulse changes its internal level only after FILTER_CYCLES consecutive cycles at the new synced level; shorter glitches are discarded.
- Undefined: no filter, FILTER_CYCLES ignored, any synced level change is an edge.

## Test plan

- Reset, Buttons=8'h09 with ButtonsValid, latch pulse, 8 pulses -> GamePadData sequence 0,1,1,0,1,1,1,1; FrameDone on 8th pulse; data 1 after; BitCount=8 then 0 in IDLE.
- Latch held high, Buttons 8'h00->8'hFF via ButtonsValid -> GamePadData 1 then 0 while latched; after fall all 8 bits read 0.
- Latch, 3 pulses, latch again -> FrameAbort one cycle, BitCount=0, data restarts at bit A.
- TIMEOUT_CYCLES=100: latch, 2 pulses, stop -> FrameAbort 100 cycles after last edge, Busy=0, data=1.
- Reset=0 for one cycle mid-SHIFT -> next cycle all outputs at reset values; subsequent frame correct.
- With GAMEPAD_RESPONDER_FILTER_EN, FILTER_CYCLES=3: 2-cycle GPulse glitch -> no shift; 5-cycle pulse -> one shift. Without macro, 2-cycle glitch -> one shift.
